// File: rtl/fifo_buffer_ctrl_if.sv
// Producer/consumer bundle for fifo_buffer_ctrl.
// The master side (producer/consumer) drives the in_* requests and the
// slave side (the FIFO) drives every out_* status and data signal.
//
// Handshake: a put is accepted on an edge where in_put=1 and the FIFO is
// not full, or is full but a take is accepted on the same edge. A take is
// accepted on an edge where in_take=1 and the FIFO is not empty. The read
// word appears on out_data one cycle later, qualified by a one-cycle
// out_valid pulse. Rejected requests only set the sticky error flags.
interface fifo_buffer_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_ASIZE = 4
);
    logic                  in_flush;
    logic                  in_put;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_take;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_empty;
    logic                  out_full;
    logic                  out_almost_empty;
    logic                  out_almost_full;
    logic [FIFO_ASIZE:0]   out_count;
    logic                  out_overflow;
    logic                  out_underflow;

    modport master (
        output in_flush, in_put, in_data, in_take,
        input  out_data, out_valid, out_empty, out_full,
        input  out_almost_empty, out_almost_full, out_count,
        input  out_overflow, out_underflow
    );

    modport slave (
        input  in_flush, in_put, in_data, in_take,
        output out_data, out_valid, out_empty, out_full,
        output out_almost_empty, out_almost_full, out_count,
        output out_overflow, out_underflow
    );
endinterface

// File: rtl/fifo_buffer_ctrl.sv
// Synchronous FIFO with its own storage, occupancy count, almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and a
// synchronous flush. Single clock domain, asynchronous active-low reset.
module fifo_buffer_ctrl #(
    parameter int DATA_WIDTH         = 8,
    parameter int FIFO_ASIZE         = 4,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input logic               in_clock,
    input logic               in_reset_n,
    fifo_buffer_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_ASIZE;
    localparam int PW    = FIFO_ASIZE + 1;

    localparam logic [PW-1:0] DEPTH_COUNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LEVEL    = PW'(ALMOST_FULL_LEVEL);
    localparam logic [PW-1:0] AE_LEVEL    = PW'(ALMOST_EMPTY_LEVEL);

    // Storage is deliberately left without reset; only written slots are read.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry an extra wrap bit; the low bits address the storage.
    logic [PW-1:0]         wptr_q, rptr_q, count_q;
    logic [PW-1:0]         wptr_d, rptr_d, count_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  empty, full;
    logic                  put_ok, take_ok;
    logic                  write_en, read_en;

    // Status flags derive from the registered count only, so they describe
    // the state left by the previous edge.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == DEPTH_COUNT);
    end

    // Accept decisions use pre-edge status. A take at full frees a slot for
    // a simultaneous put; a put at empty never feeds a simultaneous take.
    always_comb begin
        put_ok   = bus.in_put & (~full | bus.in_take);
        take_ok  = bus.in_take & ~empty;
        write_en = put_ok & ~bus.in_flush;
        read_en  = take_ok & ~bus.in_flush;
    end

    // Next-state for pointers, count, valid pulse and sticky error flags;
    // flush wins over any concurrent request and suppresses error capture.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.in_flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (put_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (take_ok) begin
                rptr_d  = rptr_q + 1'b1;
                valid_d = 1'b1;
            end
            case ({put_ok, take_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (bus.in_put && !put_ok) begin
                overflow_d = 1'b1;
            end
            if (bus.in_take && !take_ok) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control registers; reset can land at any point in a transfer.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write port.
    always_ff @(posedge in_clock) begin
        if (write_en) begin
            mem[wptr_q[FIFO_ASIZE-1:0]] <= bus.in_data;
        end
    end

    // Read data register: loads on an accepted take, otherwise holds
    // (including across a flush).
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            rdata_q <= '0;
        end else if (read_en) begin
            rdata_q <= mem[rptr_q[FIFO_ASIZE-1:0]];
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.out_data         = rdata_q;
        bus.out_valid        = valid_q;
        bus.out_empty        = empty;
        bus.out_full         = full;
        bus.out_almost_empty = (count_q <= AE_LEVEL);
        bus.out_almost_full  = (count_q >= AF_LEVEL);
        bus.out_count        = count_q;
        bus.out_overflow     = overflow_q;
        bus.out_underflow    = underflow_q;
    end

    // Occupancy must always equal the pointer distance.
    a_count_matches_ptrs : assert property (
        @(posedge in_clock) disable iff (!in_reset_n)
        count_q == PW'(wptr_q - rptr_q)
    );

endmodule

// File: tb/tb_fifo_buffer_ctrl.sv
// Self-checking bench for fifo_buffer_ctrl: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_fifo_buffer_ctrl;
  localparam int DW    = 8;
  localparam int AS    = 4;
  localparam int DEPTH = 1 << AS;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic clk;
  logic rst_n;

  fifo_buffer_ctrl_if #(.DATA_WIDTH(DW), .FIFO_ASIZE(AS)) bus ();

  fifo_buffer_ctrl #(
    .DATA_WIDTH(DW),
    .FIFO_ASIZE(AS),
    .ALMOST_FULL_LEVEL(AF),
    .ALMOST_EMPTY_LEVEL(AE)
  ) dut (
    .in_clock(clk),
    .in_reset_n(rst_n),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_data;
  logic          exp_valid;
  logic          exp_ovf;
  logic          exp_unf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".count"},  32'(bus.out_count), 32'(n));
    check({tag, ".empty"},  32'(bus.out_empty), 32'(n == 0));
    check({tag, ".full"},   32'(bus.out_full), 32'(n == DEPTH));
    check({tag, ".aempty"}, 32'(bus.out_almost_empty), 32'(n <= AE));
    check({tag, ".afull"},  32'(bus.out_almost_full), 32'(n >= AF));
    check({tag, ".valid"},  32'(bus.out_valid), 32'(exp_valid));
    check({tag, ".data"},   32'(bus.out_data), 32'(exp_data));
    check({tag, ".ovf"},    32'(bus.out_overflow), 32'(exp_ovf));
    check({tag, ".unf"},    32'(bus.out_underflow), 32'(exp_unf));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drives one cycle of requests, updates
  // the model for the coming rising edge, then checks at the next falling edge.
  task automatic step(input string tag, input logic flush, input logic put,
                      input logic [DW-1:0] data, input logic take);
    logic put_ok, take_ok;
    bus.in_flush = flush;
    bus.in_put   = put;
    bus.in_data  = data;
    bus.in_take  = take;

    take_ok = take && (exp_q.size() != 0);
    put_ok  = put && ((exp_q.size() < DEPTH) || take);
    if (flush) begin
      exp_q.delete();
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      exp_valid = take_ok;
      if (take_ok) exp_data = exp_q.pop_front();
      if (put_ok) exp_q.push_back(data);
      if (put && !put_ok) exp_ovf = 1'b1;
      if (take && !take_ok) exp_unf = 1'b1;
    end

    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
    bus.in_flush = 1'b0;
    bus.in_put   = 1'b0;
    bus.in_take  = 1'b0;
  endtask

  task automatic fill(input string tag, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, DW'(base + i), 1'b0);
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("post_reset");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    bus.in_flush = 1'b0;
    bus.in_put   = 1'b0;
    bus.in_data  = '0;
    bus.in_take  = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Fill then drain in order.
    fill("fill16", DEPTH, 8'h00);
    drain("drain16", DEPTH);

    // Overflow at full: rejected word never appears.
    fill("ovf_fill", DEPTH, 8'h20);
    step("ovf_put", 1'b0, 1'b1, 8'hAA, 1'b0);
    drain("ovf_drain", DEPTH);

    // Simultaneous put/take at full.
    do_reset();
    fill("both_fill", DEPTH, 8'h40);
    step("both_full", 1'b0, 1'b1, 8'h55, 1'b1);
    drain("both_drain", DEPTH);

    // Put+take while empty: take rejected, no pass-through.
    step("unf_both", 1'b0, 1'b1, 8'h33, 1'b1);
    step("unf_next", 1'b0, 1'b0, '0, 1'b1);

    // Wrap-around with occupancy held at 3.
    do_reset();
    fill("wrap_pre", 3, 8'h80);
    for (int i = 0; i < 40; i++) step("wrap", 1'b0, 1'b1, DW'(8'h90 + i), 1'b1);
    drain("wrap_drain", 3);

    // Flush at count 7 with both error flags set; requests during flush ignored.
    step("fl_unf", 1'b0, 1'b0, '0, 1'b1);
    fill("fl_fill", DEPTH, 8'hC0);
    step("fl_ovf", 1'b0, 1'b1, 8'hEE, 1'b0);
    drain("fl_drain9", 9);
    step("flush", 1'b1, 1'b1, 8'h77, 1'b1);

    // Async reset mid-cycle with 5 entries stored.
    fill("rst_fill", 5, 8'h10);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("after_async");

    // Randomized traffic: put-heavy, then take-heavy, then balanced.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        int pp, tp;
        pp = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
        tp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
        step("rand",
             ($urandom_range(0, 99) < 2),
             ($urandom_range(0, 99) < pp),
             DW'($urandom_range(0, 255)),
             ($urandom_range(0, 99) < tp));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
